// File: rtl/dm_port_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and the display scanner.
// The CPU wins by default; a saturating wait counter forces a scanner slot.
module dm_port_arbiter #(
  parameter int          ADDR_W     = 9,
  parameter int          DATA_W     = 32,
  parameter int          MAX_WAIT   = 3,
  parameter logic [2:0]  TYPE_WORD  = 3'b000,
  parameter logic [2:0]  TYPE_HALF  = 3'b001,
  parameter logic [2:0]  TYPE_HALFU = 3'b011
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [2:0]        cpu_type,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_misalign,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  output logic              dm_wr,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_din,
  output logic [2:0]        dm_type,
  input  logic [DATA_W-1:0] dm_dout
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic       forced;
  logic       cpu_gnt;
  logic       mis;

  // Byte types (anything that is neither word nor halfword) can never be misaligned.
  always_comb begin
    mis = 1'b0;
    if (cpu_type == TYPE_WORD) begin
      mis = (cpu_addr[1:0] != 2'b00);
    end else if ((cpu_type == TYPE_HALF) || (cpu_type == TYPE_HALFU)) begin
      mis = cpu_addr[0];
    end
  end

  assign forced    = (wait_cnt == WAIT_MAX);
  assign disp_gnt  = disp_req & (~cpu_req | forced);
  assign cpu_gnt   = cpu_req & ~disp_gnt;
  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Write enable is gated by rstn so a store in flight during reset never commits.
  always_comb begin
    dm_wr   = 1'b0;
    dm_addr = '0;
    dm_din  = '0;
    dm_type = TYPE_WORD;
    if (cpu_gnt) begin
      dm_addr = cpu_addr;
      dm_din  = cpu_wdata;
      dm_type = cpu_type;
      dm_wr   = cpu_we & ~mis & rstn;
    end else if (disp_gnt) begin
      dm_addr = disp_addr;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt <= '0;
    end else if (disp_req && !disp_gnt) begin
      wait_cnt <= forced ? WAIT_MAX : wait_cnt + 4'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      if (cpu_gnt && !cpu_we) begin
        cpu_rdata <= dm_dout;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      disp_rdata  <= '0;
      disp_rvalid <= 1'b0;
    end else begin
      disp_rvalid <= disp_gnt;
      if (disp_gnt) begin
        disp_rdata <= dm_dout;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cpu_misalign <= 1'b0;
    end else if (cpu_gnt && mis) begin
      cpu_misalign <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: word-granular memory model, directed table, directed
// corner sequences and randomized traffic checked against a rule-level reference model.
module tb_dm_port_arbiter;

  localparam int MAX_WAIT = 3;

  logic        clk;
  logic        rstn;
  logic        cpu_req, cpu_we;
  logic [8:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_type;
  logic        cpu_stall, cpu_rvalid, cpu_misalign;
  logic [31:0] cpu_rdata;
  logic        disp_req;
  logic [8:0]  disp_addr;
  logic        disp_gnt, disp_rvalid;
  logic [31:0] disp_rdata;
  logic        dm_wr;
  logic [8:0]  dm_addr;
  logic [31:0] dm_din, dm_dout;
  logic [2:0]  dm_type;

  dm_port_arbiter #(.ADDR_W(9), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_type(cpu_type), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid), .cpu_misalign(cpu_misalign),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_din(dm_din), .dm_type(dm_type),
    .dm_dout(dm_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-granular memory: combinational read, write at the posedge.
  logic [31:0] mem [128];
  logic [31:0] ref_mem [128];
  assign dm_dout = mem[dm_addr[8:2]];

  function automatic logic [31:0] preload(input int i);
    return (i == 8) ? 32'h1234_5678 : (32'h5A00_0000 | (32'(i) * 32'h0001_0203));
  endfunction

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = preload(i);
    forever begin
      @(posedge clk);
      if (dm_wr) mem[dm_addr[8:2]] <= dm_din;
    end
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  int          m_wait;
  bit          m_mis;
  logic [31:0] last_crd, last_drd;
  bit          a_stall, a_dgnt, a_wr;
  logic [8:0]  a_addr;
  logic [2:0]  a_type;
  bit          x_stall, x_dgnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_wait   = 0;
    m_mis    = 1'b0;
    last_crd = '0;
    last_drd = '0;
  endtask

  // One clock cycle: drive at negedge, check grant/mux mid-cycle, check returns after posedge.
  task automatic run_cycle(input logic c_req, input logic c_we, input logic [8:0] c_addr,
                           input logic [31:0] c_wdata, input logic [2:0] c_type,
                           input logic d_req, input logic [8:0] d_addr);
    bit e_dgnt, e_cgnt, e_mis, e_wr, e_crv, e_drv;
    logic [8:0] e_addr;
    @(negedge clk);
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wdata;
    cpu_type = c_type; disp_req = d_req; disp_addr = d_addr;
    #2;
    e_dgnt = d_req && (!c_req || m_wait >= MAX_WAIT);
    e_cgnt = c_req && !e_dgnt;
    e_mis  = (c_type == 3'b000 && c_addr[1:0] != 2'b00) ||
             ((c_type == 3'b001 || c_type == 3'b011) && c_addr[0]);
    e_wr   = e_cgnt && c_we && !e_mis;
    e_addr = e_cgnt ? c_addr : (e_dgnt ? d_addr : 9'h000);
    a_stall = cpu_stall; a_dgnt = disp_gnt; a_wr = dm_wr; a_addr = dm_addr; a_type = dm_type;
    x_stall = c_req && !e_cgnt; x_dgnt = e_dgnt;
    check("cpu_stall", 32'(cpu_stall), 32'(x_stall));
    check("disp_gnt", 32'(disp_gnt), 32'(e_dgnt));
    check("dm_wr", 32'(dm_wr), 32'(e_wr));
    check("dm_addr", 32'(dm_addr), 32'(e_addr));
    check("dm_type", 32'(dm_type), 32'(e_cgnt ? c_type : 3'b000));
    if (e_wr) check("dm_din", dm_din, c_wdata);
    @(posedge clk);
    #1;
    e_crv = e_cgnt && !c_we;
    e_drv = e_dgnt;
    if (e_crv) last_crd = ref_mem[c_addr[8:2]];
    if (e_drv) last_drd = ref_mem[d_addr[8:2]];
    if (e_wr) ref_mem[c_addr[8:2]] = c_wdata;
    if (d_req && !e_dgnt) m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
    else m_wait = 0;
    if (e_cgnt && e_mis) m_mis = 1'b1;
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
    check("disp_rvalid", 32'(disp_rvalid), 32'(e_drv));
    check("cpu_rdata", cpu_rdata, last_crd);
    check("disp_rdata", disp_rdata, last_drd);
    check("cpu_misalign", 32'(cpu_misalign), 32'(m_mis));
  endtask

  task automatic idle();
    run_cycle(1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b0, 9'h000);
  endtask

  typedef struct {
    logic        c_req;
    logic        c_we;
    logic [8:0]  c_addr;
    logic [31:0] c_wdata;
    logic [2:0]  c_type;
    logic        d_req;
    logic [8:0]  d_addr;
    logic        e_stall;
    logic        e_dgnt;
    logic        e_wr;
    logic [8:0]  e_addr;
    logic [2:0]  e_type;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic        n_req, n_we, n_dreq;
    logic [8:0]  n_addr, n_daddr;
    logic [31:0] n_wdata;
    logic [2:0]  n_type;

    tbl[0] = '{1'b1, 1'b0, 9'h004, 32'h0,         3'b000, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h004, 3'b000};
    tbl[1] = '{1'b1, 1'b1, 9'h008, 32'h1111_2222, 3'b000, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 9'h008, 3'b000};
    tbl[2] = '{1'b0, 1'b0, 9'h000, 32'h0,         3'b000, 1'b1, 9'h030, 1'b0, 1'b1, 1'b0, 9'h030, 3'b000};
    tbl[3] = '{1'b1, 1'b0, 9'h00A, 32'h0,         3'b001, 1'b1, 9'h030, 1'b0, 1'b0, 1'b0, 9'h00A, 3'b001};
    tbl[4] = '{1'b1, 1'b1, 9'h00B, 32'h3333_4444, 3'b011, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h00B, 3'b011};
    tbl[5] = '{1'b1, 1'b1, 9'h00D, 32'h5555_6666, 3'b100, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 9'h00D, 3'b100};
    tbl[6] = '{1'b0, 1'b0, 9'h000, 32'h0,         3'b000, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h000, 3'b000};
    tbl[7] = '{1'b1, 1'b1, 9'h016, 32'h7777_8888, 3'b000, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h016, 3'b000};

    for (int i = 0; i < 128; i++) ref_mem[i] = preload(i);
    model_reset();
    rstn = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_type = '0;
    disp_req = 1'b0; disp_addr = '0;
    #12;
    check("reset cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    check("reset disp_rvalid", 32'(disp_rvalid), 32'h0);
    check("reset cpu_rdata", cpu_rdata, 32'h0);
    check("reset disp_rdata", disp_rdata, 32'h0);
    check("reset cpu_misalign", 32'(cpu_misalign), 32'h0);
    check("reset dm_wr", 32'(dm_wr), 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // Store then load at 0x010.
    run_cycle(1'b1, 1'b1, 9'h010, 32'hDEAD_BEEF, 3'b000, 1'b0, 9'h000);
    check("t1 store no stall", 32'(a_stall), 32'h0);
    check("t1 store dm_wr", 32'(a_wr), 32'h1);
    run_cycle(1'b1, 1'b0, 9'h010, 32'h0, 3'b000, 1'b0, 9'h000);
    check("t1 load rvalid", 32'(cpu_rvalid), 32'h1);
    check("t1 load rdata", cpu_rdata, 32'hDEAD_BEEF);
    idle();
    check("t1 rvalid pulse ends", 32'(cpu_rvalid), 32'h0);

    // Scanner alone gets the port immediately.
    run_cycle(1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b1, 9'h020);
    check("t3 disp_gnt", 32'(a_dgnt), 32'h1);
    check("t3 cpu_stall", 32'(a_stall), 32'h0);
    check("t3 disp_rdata", disp_rdata, 32'h1234_5678);

    // Starvation: three denials, forced grant on the fourth.
    idle();
    for (int k = 0; k < 4; k++) begin
      run_cycle(1'b1, 1'b0, 9'h040, 32'h0, 3'b000, 1'b1, 9'h020);
      check("t2 disp_gnt", 32'(a_dgnt), (k == 3) ? 32'h1 : 32'h0);
      check("t2 cpu_stall", 32'(a_stall), (k == 3) ? 32'h1 : 32'h0);
      check("t2 disp_rvalid", 32'(disp_rvalid), (k == 3) ? 32'h1 : 32'h0);
    end
    check("t2 disp_rdata", disp_rdata, 32'h1234_5678);

    // Misalignment: aligned halfword is clean, misaligned word store is dropped.
    run_cycle(1'b1, 1'b0, 9'h012, 32'h0, 3'b001, 1'b0, 9'h000);
    check("t4 half ok", 32'(cpu_misalign), 32'h0);
    run_cycle(1'b1, 1'b1, 9'h013, 32'hCAFE_F00D, 3'b000, 1'b0, 9'h000);
    check("t4 store suppressed", 32'(a_wr), 32'h0);
    check("t4 misalign set", 32'(cpu_misalign), 32'h1);
    for (int k = 0; k < 20; k++) idle();
    check("t4 misalign sticky", 32'(cpu_misalign), 32'h1);
    run_cycle(1'b1, 1'b0, 9'h010, 32'h0, 3'b000, 1'b0, 9'h000);
    check("t4 memory unchanged", cpu_rdata, 32'hDEAD_BEEF);

    // Asynchronous reset with a load return pending and wait_cnt at 2.
    idle();
    run_cycle(1'b1, 1'b0, 9'h010, 32'h0, 3'b000, 1'b1, 9'h020);
    run_cycle(1'b1, 1'b0, 9'h010, 32'h0, 3'b000, 1'b1, 9'h020);
    check("t5 rvalid pending", 32'(cpu_rvalid), 32'h1);
    #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h040; cpu_wdata = 32'hFFFF_FFFF;
    cpu_type = 3'b000; disp_req = 1'b0;
    rstn = 1'b0;
    #1;
    check("t5 async cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    check("t5 async cpu_rdata", cpu_rdata, 32'h0);
    check("t5 async disp_rdata", disp_rdata, 32'h0);
    check("t5 async misalign", 32'(cpu_misalign), 32'h0);
    check("t5 dm_wr in reset", 32'(dm_wr), 32'h0);
    @(posedge clk);
    #1;
    cpu_req = 1'b0; cpu_we = 1'b0; disp_req = 1'b0;
    rstn = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      run_cycle(1'b1, 1'b0, 9'h040, 32'h0, 3'b000, 1'b1, 9'h020);
      check("t5 disp_gnt after reset", 32'(a_dgnt), (k == 3) ? 32'h1 : 32'h0);
    end
    run_cycle(1'b1, 1'b0, 9'h040, 32'h0, 3'b000, 1'b0, 9'h000);
    check("t5 reset store dropped", cpu_rdata, preload(16));

    // Directed vector table, each vector from a cleared wait counter.
    for (int i = 0; i < 8; i++) begin
      idle();
      run_cycle(tbl[i].c_req, tbl[i].c_we, tbl[i].c_addr, tbl[i].c_wdata, tbl[i].c_type,
                tbl[i].d_req, tbl[i].d_addr);
      check("tbl cpu_stall", 32'(a_stall), 32'(tbl[i].e_stall));
      check("tbl disp_gnt", 32'(a_dgnt), 32'(tbl[i].e_dgnt));
      check("tbl dm_wr", 32'(a_wr), 32'(tbl[i].e_wr));
      check("tbl dm_addr", 32'(a_addr), 32'(tbl[i].e_addr));
      check("tbl dm_type", 32'(a_type), 32'(tbl[i].e_type));
    end

    // Alternating CPU and scanner requests every cycle.
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0)
        run_cycle(1'b1, 1'($urandom_range(0, 1)), {7'($urandom_range(0, 127)), 2'b00},
                  $urandom, 3'b000, 1'b0, 9'h000);
      else
        run_cycle(1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b1, {7'($urandom_range(0, 127)), 2'b00});
    end

    // Random traffic honouring the hold-until-granted handshakes.
    n_req = 1'b0; n_we = 1'b0; n_addr = '0; n_wdata = '0; n_type = '0;
    n_dreq = 1'b0; n_daddr = '0;
    for (int i = 0; i < 300; i++) begin
      if (!(n_req && x_stall)) begin
        n_req   = ($urandom_range(0, 3) != 0);
        n_we    = 1'($urandom_range(0, 1));
        n_addr  = 9'($urandom_range(0, 511));
        n_wdata = $urandom;
        n_type  = 3'($urandom_range(0, 5));
        if ($urandom_range(0, 1) == 1) n_addr[1:0] = 2'b00;
      end
      if (!(n_dreq && !x_dgnt)) begin
        n_dreq  = ($urandom_range(0, 2) == 0);
        n_daddr = {7'($urandom_range(0, 127)), 2'b00};
      end
      run_cycle(n_req, n_we, n_addr, n_wdata, n_type, n_dreq, n_daddr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
